mouse_byte_receiver: RTL
========================

// Module: mouse_byte_receiver
// PURPOSE
//  Receives one device-to-host PS/2 frame (start, 8 data LSB-first, odd parity, stop)
//  from the mouse and hands the byte to the master state machine via a one-cycle ready pulse.
//  Sits between the transceiver's clock filter / DATA pad and the master SM; drives nothing on the bus.
//  Flags parity and stop-bit errors. Abandons stalled frames after a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  CLK cycles allowed between consecutive mouse-clock falling edges (0.5 ms @ 100 MHz)
//  CNT_W           16     width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  CLK              in   1  system clock; all logic on posedge
//  RESET            in   1  asynchronous, active-low reset
//  CLK_MOUSE_IN     in   1  filtered mouse clock level (already synchronous to CLK)
//  DATA_MOUSE_IN    in   1  raw mouse data line
//  READ_ENABLE      in   1  1 = a new frame may start; sampled only in IDLE
//  BYTE_READ        out  8  last received data byte
//  BYTE_ERROR_CODE  out  2  [0] parity error, [1] stop-bit error, for the last frame
//  BYTE_READY       out  1  one-cycle pulse: BYTE_READ/BYTE_ERROR_CODE are valid
// BEHAVIOUR
//  Reset (RESET=0, any time, async): state=IDLE, BYTE_READ=0, BYTE_ERROR_CODE=0, BYTE_READY=0,
//   shift reg=0, bit count=0, timeout count=0, ClkPrev=0. Any partial frame is discarded.
//  Edge detect: ClkPrev <= CLK_MOUSE_IN every cycle; fall = ClkPrev & ~CLK_MOUSE_IN.
//   DATA_MOUSE_IN is sampled in the same cycle fall=1.
//  FSM states and transitions (taken only on a cycle with fall=1 unless noted):
//   IDLE   : fall & READ_ENABLE & DATA=0 -> DATA, bitcnt=0. DATA=1 (glitch) or READ_ENABLE=0 -> stay IDLE.
//   DATA   : shift DATA into bit[bitcnt] (LSB first); bitcnt==7 -> PARITY, else bitcnt++.
//   PARITY : store parity bit -> STOP.
//   STOP   : store stop bit -> DONE.
//   DONE   : (no fall needed) one cycle: BYTE_READ<=data, BYTE_ERROR_CODE<={~stop, parity_err},
//            BYTE_READY=1 in the following cycle; -> IDLE.
//  parity_err = (^data ^ parity) == 0, i.e. data + parity bit must contain an odd number of 1s.
//  Latency: BYTE_READY rises 2 CLK cycles after the cycle in which the stop-bit fall is seen;
//   the outputs update in the same cycle BYTE_READY rises. BYTE_READY is high for exactly 1 cycle.
//  BYTE_READ and BYTE_ERROR_CODE hold until the next completed frame. They are not cleared on timeout.
//  Timeout: in DATA/PARITY/STOP the counter increments each cycle and clears on fall.
//   Reaching TIMEOUT_CYCLES-1 -> IDLE, no BYTE_READY, outputs unchanged. The counter is held at 0 in IDLE/DONE.
//  READ_ENABLE deasserted mid-frame: the frame still completes and BYTE_READY still pulses.
//  Errors do not suppress BYTE_READY. The master SM decides what to do with them.
//  A fall arriving in DONE is ignored. The next start bit needs a fresh fall in IDLE.
// TESTING
//  1 Frame 0xFA (DATA LSB-first 0,1,0,1,1,1,1,1, parity=1, stop=1), READ_ENABLE=1
//    -> one pulse on BYTE_READY, BYTE_READ=0xFA, BYTE_ERROR_CODE=2'b00.
//  2 Frame 0xFA with parity=0 -> BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=2'b01.
//  3 Frame 0x08 (parity=0) with stop=0 -> BYTE_READY pulse, BYTE_READ=0x08, ERROR_CODE=2'b10.
//  4 Start + 4 data bits, then mouse clock held high > TIMEOUT_CYCLES (bench: TIMEOUT_CYCLES=100)
//    -> no BYTE_READY, return to IDLE. The next full frame 0xAA (parity=1) is received correctly.
//  5 READ_ENABLE=0 during a full frame -> no BYTE_READY. READ_ENABLE=1 on the next frame 0x00
//    (parity=1) -> BYTE_READ=0x00, ERROR_CODE=2'b00.
//  6 RESET pulsed low asynchronously (not at a CLK edge) after 6 data bits -> all outputs 0 immediately,
//    no BYTE_READY from the partial frame. The following frame 0xFF (parity=1) is received correctly.

Source files
------------

// File: rtl/mouse_byte_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop.
// Delivers the byte and its error flags to the master SM with a one-cycle ready pulse.
module mouse_byte_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_clk_prev;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic             r_parity;
    logic             r_stop;
    logic [CNT_W-1:0] r_timeout;

    logic w_fall;
    logic w_expired;
    logic w_in_frame;
    logic w_start;

    assign w_fall     = r_clk_prev & ~CLK_MOUSE_IN;
    assign w_expired  = (r_timeout == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY) ||
                        (r_state == S_STOP);
    assign w_start    = w_fall & READ_ENABLE & ~DATA_MOUSE_IN;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_fall) begin
                    if (r_bitcnt == 3'd7) w_next = S_PARITY;
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            S_PARITY: begin
                if (w_fall)         w_next = S_STOP;
                else if (w_expired) w_next = S_IDLE;
            end
            S_STOP: begin
                if (w_fall)         w_next = S_DONE;
                else if (w_expired) w_next = S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_clk_prev      <= 1'b0;
            r_shift         <= 8'd0;
            r_bitcnt        <= 3'd0;
            r_parity        <= 1'b0;
            r_stop          <= 1'b0;
            r_timeout       <= '0;
            BYTE_READ       <= 8'd0;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
        end else begin
            r_clk_prev <= CLK_MOUSE_IN;
            BYTE_READY <= 1'b0;

            // Watchdog only runs while a frame is in flight
            if (w_in_frame && !w_fall && !w_expired) begin
                r_timeout <= r_timeout + 1'b1;
            end else begin
                r_timeout <= '0;
            end

            if (r_state == S_IDLE && w_start) begin
                r_bitcnt <= 3'd0;
            end

            if (r_state == S_DATA && w_fall) begin
                r_shift[r_bitcnt] <= DATA_MOUSE_IN;
                r_bitcnt          <= r_bitcnt + 3'd1;
            end

            if (r_state == S_PARITY && w_fall) begin
                r_parity <= DATA_MOUSE_IN;
            end

            if (r_state == S_STOP && w_fall) begin
                r_stop <= DATA_MOUSE_IN;
            end

            if (r_state == S_DONE) begin
                BYTE_READ       <= r_shift;
                BYTE_ERROR_CODE <= {~r_stop, ~(^r_shift ^ r_parity)};
                BYTE_READY      <= 1'b1;
            end
        end
    end

endmodule
